// File: rtl/fifo_buffer.sv
// fifo_buffer: single-clock first-word-fall-through FIFO that never stalls
// its writer. Pushes that arrive while full are dropped and flagged in a
// sticky overflow bit. Pops that arrive while empty are ignored and flagged
// in a sticky underflow bit. Occupancy comes from a registered level counter,
// so full and empty never depend on pointer comparison.
module fifo_buffer #(
  parameter int WIDTH       = 8,
  parameter int ADDR_BITS   = 4,
  parameter int AFULL_LEVEL = 12
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     wrdata,
  input  logic                 push,
  output logic [WIDTH-1:0]     rddata,
  input  logic                 pop,
  output logic                 empty,
  output logic                 full,
  output logic                 almost_full,
  output logic [ADDR_BITS:0]   level,
  output logic                 overflow,
  output logic                 underflow
);

  localparam int DEPTH = 1 << ADDR_BITS;
  localparam logic [ADDR_BITS:0] LEVEL_MAX    = (ADDR_BITS + 1)'(DEPTH);
  localparam logic [ADDR_BITS:0] AFULL_THRESH = (ADDR_BITS + 1)'(AFULL_LEVEL);

  logic [WIDTH-1:0]     mem [DEPTH];
  logic [ADDR_BITS-1:0] wr_ptr;
  logic [ADDR_BITS-1:0] rd_ptr;
  logic                 do_push;
  logic                 do_pop;
  logic                 drop_push;
  logic                 bad_pop;

  // Status flags are pure decodes of the registered level. A full FIFO still
  // takes a push when a pop frees the head slot in the same cycle. An empty
  // FIFO never forwards a same-cycle push to the pop (no bypass).
  always_comb begin
    empty       = (level == '0);
    full        = (level == LEVEL_MAX);
    almost_full = (level >= AFULL_THRESH);
    do_pop      = pop && !empty;
    do_push     = push && (!full || pop);
    drop_push   = push && full && !pop;
    bad_pop     = pop && empty;
  end

  assign rddata = mem[rd_ptr];

  // Pointers, occupancy and sticky error flags. Reset wins over any request.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
      if (drop_push) overflow  <= 1'b1;
      if (bad_pop)   underflow <= 1'b1;
    end
  end

  // Storage array is not reset. Writes are suppressed during reset so a push
  // coinciding with rst leaves no trace.
  always_ff @(posedge clk) begin
    if (!rst && do_push) mem[wr_ptr] <= wrdata;
  end

endmodule

// File: tb/tb_fifo_buffer.sv
// tb_fifo_buffer: directed scenarios followed by random traffic. The DUT is
// compared every cycle against a queue-based reference model.
module tb_fifo_buffer;

  localparam int DEPTH = 16;
  localparam int AFULL = 12;

  logic       clk;
  logic       rst;
  logic [7:0] wrdata;
  logic       push;
  logic [7:0] rddata;
  logic       pop;
  logic       empty;
  logic       full;
  logic       almost_full;
  logic [4:0] level;
  logic       overflow;
  logic       underflow;

  logic [7:0] mq[$];
  bit         m_ovf;
  bit         m_udf;
  int         total;
  int         bad;

  fifo_buffer #(.WIDTH(8), .ADDR_BITS(4), .AFULL_LEVEL(AFULL)) dut (
    .clk(clk), .rst(rst), .wrdata(wrdata), .push(push), .rddata(rddata),
    .pop(pop), .empty(empty), .full(full), .almost_full(almost_full),
    .level(level), .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput(input string tag);
    int n;
    n = mq.size();
    check({tag, ".level"}, 32'(level), 32'(n));
    check({tag, ".empty"}, 32'(empty), 32'(n == 0));
    check({tag, ".full"}, 32'(full), 32'(n == DEPTH));
    check({tag, ".almost_full"}, 32'(almost_full), 32'(n >= AFULL));
    check({tag, ".overflow"}, 32'(overflow), 32'(m_ovf));
    check({tag, ".underflow"}, 32'(underflow), 32'(m_udf));
    if (n > 0) check({tag, ".rddata"}, 32'(rddata), 32'(mq[0]));
  endtask

  task automatic applyStimulus(input logic r, input logic p, input logic po,
                               input logic [7:0] d, input string tag);
    int n;
    rst = r; push = p; pop = po; wrdata = d;
    @(posedge clk);
    n = mq.size();
    if (r) begin
      mq.delete();
      m_ovf = 0;
      m_udf = 0;
    end else begin
      if (po) begin
        if (n == 0) m_udf = 1;
        else void'(mq.pop_front());
      end
      if (p) begin
        if (n < DEPTH || po) mq.push_back(d);
        else m_ovf = 1;
      end
    end
    #1;
    rst = 0; push = 0; pop = 0;
    checkOutput(tag);
  endtask

  initial begin
    clk = 0; rst = 1; push = 0; pop = 0; wrdata = 0;
    total = 0; bad = 0; m_ovf = 0; m_udf = 0;
    #2;

    applyStimulus(1, 0, 0, 8'h00, "reset");
    check("reset.empty_const", 32'(empty), 32'd1);
    check("reset.level_const", 32'(level), 32'd0);

    applyStimulus(0, 1, 0, 8'h11, "basic.push1");
    check("basic.first_word", 32'(rddata), 32'h11);
    applyStimulus(0, 1, 0, 8'h22, "basic.push2");
    applyStimulus(0, 1, 0, 8'h33, "basic.push3");
    check("basic.level3", 32'(level), 32'd3);
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 1, 8'h00, "basic.pop");
    check("basic.drained", 32'(empty), 32'd1);

    for (int i = 0; i < 16; i++) applyStimulus(0, 1, 0, 8'(i), "fill.push");
    check("fill.full_const", 32'(full), 32'd1);
    applyStimulus(0, 1, 0, 8'hAA, "fill.extra");
    check("fill.ovf_const", 32'(overflow), 32'd1);
    check("fill.level16", 32'(level), 32'd16);
    for (int i = 0; i < 16; i++) begin
      check("fill.drain_value", 32'(rddata), 32'(i));
      applyStimulus(0, 0, 1, 8'h00, "fill.pop");
    end

    applyStimulus(1, 0, 0, 8'h00, "reset2");
    for (int i = 0; i < 16; i++) applyStimulus(0, 1, 0, 8'(i), "pp.fill");
    applyStimulus(0, 1, 1, 8'hBB, "pp.full_pushpop");
    check("pp.no_ovf", 32'(overflow), 32'd0);
    for (int i = 0; i < 16; i++) applyStimulus(0, 0, 1, 8'h00, "pp.drain");

    applyStimulus(1, 0, 0, 8'h00, "reset3");
    for (int i = 0; i < 5; i++) applyStimulus(0, 1, 0, 8'(i), "stream.prefill");
    for (int i = 5; i < 45; i++) begin
      check("stream.head", 32'(rddata), 32'(i - 5));
      applyStimulus(0, 1, 1, 8'(i), "stream.step");
    end
    check("stream.level5", 32'(level), 32'd5);

    applyStimulus(1, 0, 0, 8'h00, "reset4");
    applyStimulus(0, 0, 1, 8'h00, "udf.pop_empty");
    check("udf.flag_const", 32'(underflow), 32'd1);
    applyStimulus(0, 1, 1, 8'h5A, "udf.pushpop_empty");
    check("udf.rddata_const", 32'(rddata), 32'h5A);

    applyStimulus(1, 0, 0, 8'h00, "reset5");
    for (int i = 0; i < 17; i++) applyStimulus(0, 1, 0, 8'(i + 8'h40), "mid.fill");
    for (int i = 0; i < 9; i++) applyStimulus(0, 0, 1, 8'h00, "mid.pop");
    check("mid.level7", 32'(level), 32'd7);
    applyStimulus(1, 1, 1, 8'hEE, "mid.reset");
    applyStimulus(0, 0, 0, 8'h00, "mid.after");
    check("mid.empty_const", 32'(empty), 32'd1);

    for (int i = 0; i < 400; i++) begin
      logic r, p, po;
      r  = ($urandom_range(0, 99) < 2);
      p  = ($urandom_range(0, 99) < 60);
      po = ($urandom_range(0, 99) < 45);
      applyStimulus(r, p, po, 8'($urandom), "random");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
